// File: rtl/prog_rom_arbiter.sv
// Two-requester arbiter for the shared single-port program ROM.
// CPU fetch has priority; the debug port gets one slot after MAX_WAIT consecutive losses.
module prog_rom_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic              CPU_STALL,
  output logic [DATA_W-1:0] CPU_IR,
  output logic              CPU_VALID,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic              DBG_READY,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_RVALID,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_IR
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_CPU  = 2'b01,
    RESP_DBG  = 2'b10
  } resp_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic              gnt_dbg_s;
  logic              gnt_cpu_s;
  logic [ADDR_W-1:0] rom_addr_s;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  resp_e             resp_q, resp_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;

  // Grant decision and ROM address mux; idle cycles replay the last address
  always_comb begin
    gnt_dbg_s  = DBG_REQ & (~CPU_REQ | (wait_cnt_q == MAX_WAIT_C));
    gnt_cpu_s  = CPU_REQ & ~gnt_dbg_s;
    rom_addr_s = last_addr_q;
    if (gnt_cpu_s) begin
      rom_addr_s = CPU_ADDR;
    end else if (gnt_dbg_s) begin
      rom_addr_s = DBG_ADDR;
    end else begin
      rom_addr_s = last_addr_q;
    end
  end

  // Next-state: starvation counter, response tag, replay address, debug capture
  always_comb begin
    wait_cnt_d   = 4'd0;
    resp_d       = RESP_NONE;
    last_addr_d  = last_addr_q;
    dbg_data_d   = dbg_data_q;
    dbg_rvalid_d = 1'b0;

    if (DBG_REQ & ~gnt_dbg_s) begin
      if (wait_cnt_q < MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end

    if (gnt_cpu_s) begin
      resp_d = RESP_CPU;
    end else if (gnt_dbg_s) begin
      resp_d = RESP_DBG;
    end else begin
      resp_d = RESP_NONE;
    end

    if (gnt_cpu_s | gnt_dbg_s) begin
      last_addr_d = rom_addr_s;
    end else begin
      last_addr_d = last_addr_q;
    end

    // ROM_IR belongs to the debug port in the cycle after its grant
    if (resp_q == RESP_DBG) begin
      dbg_data_d   = ROM_IR;
      dbg_rvalid_d = 1'b1;
    end else begin
      dbg_data_d   = dbg_data_q;
      dbg_rvalid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q   <= 4'd0;
      resp_q       <= RESP_NONE;
      last_addr_q  <= '0;
      dbg_data_q   <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_q       <= resp_d;
      last_addr_q  <= last_addr_d;
      dbg_data_q   <= dbg_data_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign CPU_STALL  = CPU_REQ & ~gnt_cpu_s;
  assign DBG_READY  = gnt_dbg_s;
  assign ROM_ADDR   = rom_addr_s;
  assign CPU_IR     = ROM_IR;
  assign CPU_VALID  = (resp_q == RESP_CPU);
  assign DBG_DATA   = dbg_data_q;
  assign DBG_RVALID = dbg_rvalid_q;

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Bench for prog_rom_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_prog_rom_arbiter;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int MW = 4;

  logic clk;
  logic rst;

  logic [DW-1:0] rom_mem [1024];

  // instance with MAX_WAIT=4
  logic          c_req, c_stall, c_valid, d_req, d_ready, d_rvalid;
  logic [AW-1:0] c_addr, d_addr, rom_addr;
  logic [DW-1:0] c_ir, d_data, rom_ir;
  // instance with MAX_WAIT=1
  logic          c_req1, c_stall1, c_valid1, d_req1, d_ready1, d_rvalid1;
  logic [AW-1:0] c_addr1, d_addr1, rom_addr1;
  logic [DW-1:0] c_ir1, d_data1, rom_ir1;

  int n_checks = 0;
  int n_err    = 0;

  prog_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut4 (
    .CLK(clk), .RST(rst),
    .CPU_REQ(c_req), .CPU_ADDR(c_addr), .CPU_STALL(c_stall), .CPU_IR(c_ir), .CPU_VALID(c_valid),
    .DBG_REQ(d_req), .DBG_ADDR(d_addr), .DBG_READY(d_ready), .DBG_DATA(d_data), .DBG_RVALID(d_rvalid),
    .ROM_ADDR(rom_addr), .ROM_IR(rom_ir)
  );

  prog_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(1)) dut1 (
    .CLK(clk), .RST(rst),
    .CPU_REQ(c_req1), .CPU_ADDR(c_addr1), .CPU_STALL(c_stall1), .CPU_IR(c_ir1), .CPU_VALID(c_valid1),
    .DBG_REQ(d_req1), .DBG_ADDR(d_addr1), .DBG_READY(d_ready1), .DBG_DATA(d_data1), .DBG_RVALID(d_rvalid1),
    .ROM_ADDR(rom_addr1), .ROM_IR(rom_ir1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM models, one-cycle registered read
  always @(posedge clk) begin
    rom_ir  <= rom_mem[rom_addr];
    rom_ir1 <= rom_mem[rom_addr1];
  end

  function automatic logic [DW-1:0] rom_f(input int i);
    return DW'((i * 2731 + 5) ^ (i << 8));
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          creq;
    logic [AW-1:0] caddr;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          e_stall;
    logic          e_ready;
    logic [AW-1:0] e_rom;
    logic          e_cvalid;
    logic [DW-1:0] e_cir;
    logic          e_rvalid;
    logic [DW-1:0] e_ddata;
  } vec_t;

  function automatic vec_t mk(input logic cr, input logic [AW-1:0] ca, input logic dr,
                              input logic [AW-1:0] da, input logic es, input logic er,
                              input logic [AW-1:0] erom, input logic ecv, input logic [DW-1:0] ecir,
                              input logic erv, input logic [DW-1:0] edd);
    vec_t v;
    v.creq = cr; v.caddr = ca; v.dreq = dr; v.daddr = da;
    v.e_stall = es; v.e_ready = er; v.e_rom = erom;
    v.e_cvalid = ecv; v.e_cir = ecir; v.e_rvalid = erv; v.e_ddata = edd;
    return v;
  endfunction

  vec_t vt [15];

  initial begin
    logic [DW-1:0] r3ff, r100;
    // reference-model state for the randomized run
    int            m_loss, act_loss;
    logic          m_pc, m_dv1, m_dv2, cpu_hold, dbg_pend, exp_gd, exp_gc;
    logic [AW-1:0] m_pca, m_dv1a, m_dv2a, m_last, exp_rom;
    logic [DW-1:0] m_ddata;
    // alternation sequence state
    logic          a_pc, a_dv1, a_dv2, a_d, a_c;
    logic [AW-1:0] a_ca, a_da, a_pca, a_dv1a, a_dv2a, a_last, a_rom;

    for (int i = 0; i < 1024; i++) rom_mem[i] = rom_f(i);
    r3ff = rom_f(32'h3FF);
    r100 = rom_f(32'h100);

    vt[0]  = mk(1'b1, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 18'h0,        1'b0, 18'h0);
    vt[1]  = mk(1'b1, 10'h001, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001, 1'b1, rom_f(32'h0),  1'b0, 18'h0);
    vt[2]  = mk(1'b1, 10'h002, 1'b0, 10'h000, 1'b0, 1'b0, 10'h002, 1'b1, rom_f(32'h1),  1'b0, 18'h0);
    vt[3]  = mk(1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 1'b1, rom_f(32'h2),  1'b0, 18'h0);
    vt[4]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 1'b0, 18'h0,        1'b0, 18'h0);
    vt[5]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 1'b0, 18'h0,        1'b1, r3ff);
    vt[6]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h3FF, 1'b0, 18'h0,        1'b0, r3ff);
    vt[7]  = mk(1'b1, 10'h010, 1'b1, 10'h100, 1'b0, 1'b0, 10'h010, 1'b0, 18'h0,        1'b0, r3ff);
    vt[8]  = mk(1'b1, 10'h011, 1'b1, 10'h100, 1'b0, 1'b0, 10'h011, 1'b1, rom_f(32'h10), 1'b0, r3ff);
    vt[9]  = mk(1'b1, 10'h012, 1'b1, 10'h100, 1'b0, 1'b0, 10'h012, 1'b1, rom_f(32'h11), 1'b0, r3ff);
    vt[10] = mk(1'b1, 10'h013, 1'b1, 10'h100, 1'b0, 1'b0, 10'h013, 1'b1, rom_f(32'h12), 1'b0, r3ff);
    vt[11] = mk(1'b1, 10'h014, 1'b1, 10'h100, 1'b1, 1'b1, 10'h100, 1'b1, rom_f(32'h13), 1'b0, r3ff);
    vt[12] = mk(1'b1, 10'h014, 1'b0, 10'h000, 1'b0, 1'b0, 10'h014, 1'b0, 18'h0,        1'b0, r3ff);
    vt[13] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h014, 1'b1, rom_f(32'h14), 1'b1, r100);
    vt[14] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h014, 1'b0, 18'h0,        1'b0, r100);

    rst = 1'b1;
    c_req = 1'b0; c_addr = '0; d_req = 1'b0; d_addr = '0;
    c_req1 = 1'b0; c_addr1 = '0; d_req1 = 1'b0; d_addr1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_cpu_valid", c_valid, 1'b0);
    chk1("rst_dbg_rvalid", d_rvalid, 1'b0);
    chkd("rst_dbg_data", d_data, 18'h0);
    chka("rst_rom_addr", rom_addr, 10'h000);
    rst = 1'b0;

    // directed vectors: CPU burst, DBG idle read, contention with MAX_WAIT=4
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      c_req = vt[i].creq; c_addr = vt[i].caddr; d_req = vt[i].dreq; d_addr = vt[i].daddr;
      #1;
      chk1($sformatf("v%0d_stall", i), c_stall, vt[i].e_stall);
      chk1($sformatf("v%0d_ready", i), d_ready, vt[i].e_ready);
      chka($sformatf("v%0d_rom_addr", i), rom_addr, vt[i].e_rom);
      chk1($sformatf("v%0d_cpu_valid", i), c_valid, vt[i].e_cvalid);
      if (vt[i].e_cvalid) chkd($sformatf("v%0d_cpu_ir", i), c_ir, vt[i].e_cir);
      chk1($sformatf("v%0d_dbg_rvalid", i), d_rvalid, vt[i].e_rvalid);
      chkd($sformatf("v%0d_dbg_data", i), d_data, vt[i].e_ddata);
    end

    // MAX_WAIT=1: strict alternation under continuous contention, then drain
    a_pc = 1'b0; a_dv1 = 1'b0; a_dv2 = 1'b0; a_pca = '0; a_dv1a = '0; a_dv2a = '0;
    a_ca = 10'h050; a_da = 10'h200; a_last = 10'h000;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      c_req1 = (i < 10); c_addr1 = a_ca; d_req1 = (i < 10); d_addr1 = a_da;
      a_d = (i < 10) && (i % 2 == 1);
      a_c = (i < 10) && !a_d;
      a_rom = a_c ? a_ca : (a_d ? a_da : a_last);
      #1;
      chk1($sformatf("alt%0d_ready", i), d_ready1, a_d);
      chk1($sformatf("alt%0d_stall", i), c_stall1, a_d);
      chka($sformatf("alt%0d_rom_addr", i), rom_addr1, a_rom);
      chk1($sformatf("alt%0d_cpu_valid", i), c_valid1, a_pc);
      if (a_pc) chkd($sformatf("alt%0d_cpu_ir", i), c_ir1, rom_mem[a_pca]);
      chk1($sformatf("alt%0d_dbg_rvalid", i), d_rvalid1, a_dv2);
      if (a_dv2) chkd($sformatf("alt%0d_dbg_data", i), d_data1, rom_mem[a_dv2a]);
      a_pc = a_c; a_pca = a_ca;
      a_dv2 = a_dv1; a_dv2a = a_dv1a; a_dv1 = a_d; a_dv1a = a_da;
      if (a_c | a_d) a_last = a_rom;
      if (a_d) a_da = a_da + 10'd1;
      if (a_c) a_ca = a_ca + 10'd1;
    end

    // reset asserted in the cycle after a DBG grant discards the response
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b1; d_addr = 10'h055;
    #1;
    chk1("rstmid_grant", d_ready, 1'b1);
    chka("rstmid_rom_addr", rom_addr, 10'h055);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk1("rstmid_rvalid_a", d_rvalid, 1'b0);
    chkd("rstmid_data_a", d_data, 18'h0);
    chk1("rstmid_cpu_valid", c_valid, 1'b0);
    chk1("rstmid_wait_cnt", dut4.wait_cnt_q == 4'd0, 1'b1);
    @(negedge clk);
    #1;
    chk1("rstmid_rvalid_b", d_rvalid, 1'b0);
    chkd("rstmid_data_b", d_data, 18'h0);
    @(negedge clk);
    rst = 1'b0; c_req = 1'b1; c_addr = 10'h077;
    #1;
    chk1("post_rst_stall", c_stall, 1'b0);
    chka("post_rst_rom_addr", rom_addr, 10'h077);
    chk1("post_rst_rvalid", d_rvalid, 1'b0);
    @(negedge clk);
    c_req = 1'b0;
    #1;
    chk1("post_rst_cpu_valid", c_valid, 1'b1);
    chkd("post_rst_cpu_ir", c_ir, rom_mem[10'h077]);
    chk1("post_rst_rvalid2", d_rvalid, 1'b0);
    chkd("post_rst_data", d_data, 18'h0);

    // randomized interleaving against a transaction-level model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_loss = 0; act_loss = 0; m_pc = 1'b0; m_pca = '0;
    m_dv1 = 1'b0; m_dv2 = 1'b0; m_dv1a = '0; m_dv2a = '0;
    m_last = '0; m_ddata = '0; cpu_hold = 1'b0; dbg_pend = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!cpu_hold) begin
        c_req  = ($urandom_range(3, 0) != 0);
        c_addr = AW'($urandom_range(1023, 0));
      end
      if (dbg_pend) begin
        if ($urandom_range(39, 0) == 0) d_req = 1'b0;
      end else begin
        d_req  = ($urandom_range(2, 0) == 0);
        d_addr = AW'($urandom_range(1023, 0));
      end
      exp_gd  = d_req && (!c_req || m_loss == MW);
      exp_gc  = c_req && !exp_gd;
      exp_rom = exp_gc ? c_addr : (exp_gd ? d_addr : m_last);
      if (m_dv2) m_ddata = rom_mem[m_dv2a];
      #1;
      chk1("rnd_ready", d_ready, exp_gd);
      chk1("rnd_stall", c_stall, c_req && !exp_gc);
      chka("rnd_rom_addr", rom_addr, exp_rom);
      chk1("rnd_cpu_valid", c_valid, m_pc);
      if (m_pc) chkd("rnd_cpu_ir", c_ir, rom_mem[m_pca]);
      chk1("rnd_dbg_rvalid", d_rvalid, m_dv2);
      chkd("rnd_dbg_data", d_data, m_ddata);
      act_loss = (d_req && !d_ready) ? act_loss + 1 : 0;
      chk1("rnd_wait_bound", act_loss <= MW, 1'b1);
      m_loss   = (d_req && !exp_gd) ? m_loss + 1 : 0;
      m_pc     = exp_gc; m_pca = c_addr;
      m_dv2    = m_dv1; m_dv2a = m_dv1a; m_dv1 = exp_gd; m_dv1a = d_addr;
      if (exp_gc || exp_gd) m_last = exp_rom;
      cpu_hold = c_req && !exp_gc;
      dbg_pend = d_req && !exp_gd;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/prog_rom_arbiter.md
Name: prog_rom_arbiter

Overview:
- Shares the single-port, 1024x18 synchronous program ROM (1-cycle registered read) between two requesters: the MCU instruction fetch (CPU) and a debug/readback port (DBG).
- CPU has fixed priority. DBG is guaranteed a slot after a bounded wait.
- Sits between the program counter/fetch logic and the ROM instance, and tags each ROM read so its data returns to the requester that issued it.

Parameters:
- ADDR_W, 10, ROM address width.
- DATA_W, 18, instruction width.
- MAX_WAIT, 4, max consecutive cycles a pending DBG request may lose to CPU; legal range 1..15.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- CPU_REQ  in  1  CPU fetch request this cycle
- CPU_ADDR  in  ADDR_W  CPU fetch address
- CPU_STALL  out  1  CPU request not granted this cycle; CPU must hold CPU_ADDR
- CPU_IR  out  DATA_W  instruction for CPU (valid when CPU_VALID)
- CPU_VALID  out  1  CPU_IR carries data for the CPU read granted last cycle
- DBG_REQ  in  1  debug read request (valid), held until DBG_READY
- DBG_ADDR  in  ADDR_W  debug read address, stable while DBG_REQ high
- DBG_READY  out  1  debug request accepted this cycle
- DBG_DATA  out  DATA_W  last debug read result, held until next debug read completes
- DBG_RVALID  out  1  one-cycle pulse: DBG_DATA newly updated
- ROM_ADDR  out  ADDR_W  to ROM address input
- ROM_IR  in  DATA_W  from ROM registered output

Behaviour:
- Grant (combinational, per cycle):
  - gnt_dbg = DBG_REQ & (~CPU_REQ | wait_cnt == MAX_WAIT)
  - gnt_cpu = CPU_REQ & ~gnt_dbg
- Outputs from grant:
  - DBG_READY = gnt_dbg
  - CPU_STALL = CPU_REQ & ~gnt_cpu
- ROM_ADDR:
  - CPU_ADDR if gnt_cpu; DBG_ADDR if gnt_dbg.
  - Otherwise last_addr, a register loaded with ROM_ADDR on every granted cycle, so the ROM output is stable when idle.
- wait_cnt (width 4):
  - Cleared when DBG_REQ low or gnt_dbg.
  - Incremented when DBG_REQ & ~gnt_dbg.
  - Never exceeds MAX_WAIT.
- Response tag register resp ∈ {NONE, CPU, DBG}, loaded every cycle from the grant: CPU if gnt_cpu, DBG if gnt_dbg, else NONE.
- Latency:
  - Read granted in cycle t returns ROM_IR in cycle t+1.
  - CPU_IR = ROM_IR (pass-through, no added latency); CPU_VALID = (resp == CPU) in t+1.
  - When resp == DBG in t+1, DBG_DATA is captured from ROM_IR at the end of t+1 and DBG_RVALID pulses in t+2.
- Back-to-back: one grant per cycle; CPU and DBG reads may interleave every cycle with no bubbles.
- Simultaneous requests: CPU wins until wait_cnt == MAX_WAIT, then DBG wins exactly one cycle. After that, CPU wins again and the counter restarts. With MAX_WAIT=1 the two strictly alternate under continuous contention.
- DBG_REQ dropped before acceptance: no read issued, counter cleared. Protocol violation; it must not corrupt state.
- Reset:
  - All outputs are driven from reset registers or from combinational logic of inputs and reset registers.
  - Reset values: wait_cnt=0, resp=NONE, last_addr=0, DBG_DATA=0, DBG_RVALID=0.
  - Hence CPU_VALID=0 and ROM_ADDR=0 when no requests are present.
  - Reset mid-operation discards in-flight responses: no CPU_VALID or DBG_RVALID for reads granted in the cycle reset asserts.
  - First grant is possible in the first clock after RST deasserts.

Test Plan:
- After reset, CPU_REQ=1 with CPU_ADDR=0x000,0x001,0x002 on consecutive cycles, DBG_REQ=0 -> CPU_STALL=0 throughout; CPU_VALID high from the 2nd cycle; CPU_IR = rom[0],rom[1],rom[2] one cycle after each address.
- CPU idle, DBG_REQ=1 with DBG_ADDR=0x3FF -> DBG_READY=1 same cycle, ROM_ADDR=0x3FF; DBG_RVALID pulses 2 cycles later with DBG_DATA=rom[0x3FF]; DBG_DATA holds afterwards, ROM_ADDR stays 0x3FF while idle.
- CPU_REQ=1 continuously and DBG_REQ=1 at DBG_ADDR=0x100 with MAX_WAIT=4 -> CPU granted 4 cycles; 5th cycle DBG_READY=1, CPU_STALL=1, ROM_ADDR=0x100; no CPU_VALID the following cycle; CPU resumes the next cycle with CPU_ADDR unchanged.
- Continuous contention, MAX_WAIT=1 -> grants alternate CPU,DBG,CPU,DBG; each DBG_RVALID carries the correct address's data; CPU_VALID never coincides with a DBG-tagged response.
- Assert RST in the cycle after a DBG grant -> DBG_RVALID never pulses, DBG_DATA=0, wait_cnt=0; a normal CPU read succeeds after release.
- Random interleaving of CPU_REQ/DBG_REQ over 10k cycles against a scoreboard -> every accepted request returns exactly once with rom[addr]; no DBG wait exceeds MAX_WAIT cycles.
